// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC core among N_REQ requesters.
// Each grant runs the core through reset, start and done/timeout, then holds the result until the requester accepts it.
module cordic_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_angle,
    output logic [N_REQ-1:0]     resp_valid,
    input  logic [N_REQ-1:0]     resp_ready,
    output logic [15:0]          resp_cos,
    output logic [15:0]          resp_sin,
    output logic                 resp_err,
    output logic                 core_rst,
    output logic                 core_valid_in,
    output logic [31:0]          core_angle,
    input  logic [15:0]          core_cos,
    input  logic [15:0]          core_sin,
    input  logic                 core_done,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CRST  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]       state, state_d;
    logic [ID_W-1:0]  last_grant, last_d, grant_d;
    logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
    logic [31:0]      angle_d, pick_angle;
    logic [15:0]      cos_d, sin_d;
    logic             err_d;
    logic             found;
    logic [ID_W-1:0]  pick, cand;

    // Round-robin search: walk downward so the closest index after last_grant wins
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int unsigned k = N_REQ; k > 0; k--) begin
            cand = ID_W'((32'(last_grant) + k) % N_REQ);
            if (1'(req_valid >> cand)) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign pick_angle = 32'(req_angle >> (32'(pick) * 32));
    assign cnt_inc    = cnt + CNT_W'(1);

    always_comb begin
        state_d = state;
        grant_d = grant_id;
        last_d  = last_grant;
        angle_d = core_angle;
        cos_d   = resp_cos;
        sin_d   = resp_sin;
        err_d   = resp_err;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_d = S_CRST;
                    grant_d = pick;
                    last_d  = pick;
                    angle_d = pick_angle;
                end
            end
            S_CRST:  state_d = S_START;
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (core_done) begin
                    cos_d   = core_cos;
                    sin_d   = core_sin;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    cos_d   = '0;
                    sin_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RESP: begin
                if (1'(resp_ready >> grant_id)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant_id   <= '0;
            last_grant <= ID_W'(N_REQ - 1);
            core_angle <= '0;
            resp_cos   <= '0;
            resp_sin   <= '0;
            resp_err   <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_d;
            grant_id   <= grant_d;
            last_grant <= last_d;
            core_angle <= angle_d;
            resp_cos   <= cos_d;
            resp_sin   <= sin_d;
            resp_err   <= err_d;
            cnt        <= cnt_d;
        end
    end

    // Handshake strobes decoded from the state register
    assign req_ready     = (state == S_IDLE && found) ? (N_REQ'(1) << pick) : '0;
    assign resp_valid    = (state == S_RESP) ? (N_REQ'(1) << grant_id) : '0;
    assign core_rst      = rst | (state == S_CRST);
    assign core_valid_in = (state == S_START);
    assign busy          = (state != S_IDLE);

endmodule
